// File: rtl/system_nios2_cpu_debug_host_driver_if.sv
// Command, response and virtual-JTAG signals of the Nios II debug host driver.
// master = host/script side issuing commands, slave = the driver block itself.
`timescale 1ns/1ps
interface system_nios2_cpu_debug_host_driver_if #(
  parameter int SR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [SR_WIDTH-1:0] rsp_data;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [1:0]          vji_ir_in;
  logic                vji_rti;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data,
    input  vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data,
    output vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );
endinterface

// File: rtl/system_nios2_cpu_debug_host_driver.sv
// Nios II virtual-JTAG debug host: runs one UIR/CDR/SDR/UDR sequence per command.
// Optional macro DEBUG_HOST_IR_CACHE_EN skips UIR when the IR matches the last one issued.
`timescale 1ns/1ps
module system_nios2_cpu_debug_host_driver #(
  parameter int SR_WIDTH = 38,
  parameter int TCK_HALF = 2
) (
  input logic clk,
  input logic reset_n,
  system_nios2_cpu_debug_host_driver_if.slave bus
);

  localparam int              BW       = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(SR_WIDTH - 1);
  localparam logic [4:0]      TCK_LAST = 5'(2 * TCK_HALF - 1);
  localparam logic [4:0]      TCK_RISE = 5'(TCK_HALF - 1);

  // S_ARM is the single clk between acceptance and the first TCK period.
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_UIR, S_CDR, S_SDR, S_UDR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_tck_cnt;
  logic                r_tck;
  logic [BW-1:0]       r_bit_cnt;
  logic [1:0]          r_cmd_ir;
  logic [1:0]          r_ir;
  logic [SR_WIDTH-1:0] r_data;
  logic [SR_WIDTH-1:0] r_rsp;
  logic                r_rsp_valid;
`ifdef DEBUG_HOST_IR_CACHE_EN
  logic                r_ir_valid;
  logic                r_skip_uir;
`endif

  logic w_accept;
  logic w_active;
  logic w_period_end;
  logic w_tck_rise;
  logic w_cmd_ready;
  logic w_rti;
  logic w_uir;
  logic w_cdr;
  logic w_sdr;
  logic w_udr;
  logic w_tdi;

  assign w_active     = (r_state == S_UIR) || (r_state == S_CDR) ||
                        (r_state == S_SDR) || (r_state == S_UDR);
  assign w_accept     = bus.cmd_valid && (r_state == S_IDLE);
  assign w_period_end = w_active && (r_tck_cnt == TCK_LAST);
  assign w_tck_rise   = w_active && (r_tck_cnt == TCK_RISE);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_rti       = 1'b0;
    w_uir       = 1'b0;
    w_cdr       = 1'b0;
    w_sdr       = 1'b0;
    w_udr       = 1'b0;
    w_tdi       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_rti       = 1'b1;
        if (bus.cmd_valid) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_rti = 1'b1;
`ifdef DEBUG_HOST_IR_CACHE_EN
        w_state_nxt = r_skip_uir ? S_CDR : S_UIR;
`else
        w_state_nxt = S_UIR;
`endif
      end
      S_UIR: begin
        w_uir = 1'b1;
        if (w_period_end) w_state_nxt = S_CDR;
      end
      S_CDR: begin
        w_cdr = 1'b1;
        if (w_period_end) w_state_nxt = S_SDR;
      end
      S_SDR: begin
        w_sdr = 1'b1;
        w_tdi = r_data[0];
        if (w_period_end && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_UDR;
      end
      S_UDR: begin
        w_udr = 1'b1;
        if (w_period_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tck_cnt   <= '0;
      r_tck       <= 1'b0;
      r_bit_cnt   <= '0;
      r_cmd_ir    <= '0;
      r_ir        <= '0;
      r_data      <= '0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
`ifdef DEBUG_HOST_IR_CACHE_EN
      r_ir_valid  <= 1'b0;
      r_skip_uir  <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= (r_state == S_UDR) && w_period_end;

      if (w_accept) begin
        r_cmd_ir <= bus.cmd_ir;
        r_data   <= bus.cmd_data;
`ifdef DEBUG_HOST_IR_CACHE_EN
        r_skip_uir <= r_ir_valid && (bus.cmd_ir == r_ir);
`endif
      end

      // The presented IR only changes at the edge that opens a UIR period.
      if (r_state == S_ARM) begin
`ifdef DEBUG_HOST_IR_CACHE_EN
        if (!r_skip_uir) begin
          r_ir       <= r_cmd_ir;
          r_ir_valid <= 1'b1;
        end
`else
        r_ir <= r_cmd_ir;
`endif
      end

      if (w_active) begin
        if (w_period_end) begin
          r_tck_cnt <= '0;
          r_tck     <= 1'b0;
        end else begin
          r_tck_cnt <= r_tck_cnt + 5'd1;
          if (w_tck_rise) r_tck <= 1'b1;
        end
      end

      // TDO is sampled on the clk edge that raises TCK; TDI advances at the period boundary.
      if ((r_state == S_SDR) && w_tck_rise)
        r_rsp <= {bus.vji_tdo, r_rsp[SR_WIDTH-1:1]};

      if ((r_state == S_SDR) && w_period_end) begin
        r_data    <= r_data >> 1;
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp;
  assign bus.vji_tck   = r_tck;
  assign bus.vji_tdi   = w_tdi;
  assign bus.vji_ir_in = r_ir;
  assign bus.vji_rti   = w_rti;
  assign bus.vji_uir   = w_uir;
  assign bus.vji_cdr   = w_cdr;
  assign bus.vji_sdr   = w_sdr;
  assign bus.vji_udr   = w_udr;

endmodule

// File: tb/tb_system_nios2_cpu_debug_host_driver.sv
// Bench for the debug host driver: slave shift-register model on dut0 (TCK_HALF=2),
// TDI->TDO loopback on dut1 (TCK_HALF=1) for strobe widths; scoreboard of responses.
`timescale 1ns/1ps
module tb_system_nios2_cpu_debug_host_driver;

  localparam int W   = 38;
  localparam int TH  = 2;
  localparam int TH1 = 1;
`ifdef DEBUG_HOST_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int LAT  = 1 + (W + 3) * 2 * TH;
  localparam int LAT1 = 1 + (W + 3) * 2 * TH1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  system_nios2_cpu_debug_host_driver_if #(.SR_WIDTH(W)) bus0 ();
  system_nios2_cpu_debug_host_driver_if #(.SR_WIDTH(W)) bus1 ();

  system_nios2_cpu_debug_host_driver #(.SR_WIDTH(W), .TCK_HALF(TH)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  system_nios2_cpu_debug_host_driver #(.SR_WIDTH(W), .TCK_HALF(TH1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave model: capture on CDR, shift right with TDI entering at the top during SDR.
  logic [W-1:0] slv_sr  = '0;
  logic [W-1:0] slv_cap = '0;
  always @(posedge bus0.vji_tck) begin
    if (bus0.vji_cdr)      slv_sr <= slv_cap;
    else if (bus0.vji_sdr) slv_sr <= {bus0.vji_tdi, slv_sr[W-1:1]};
  end
  assign bus0.vji_tdo = slv_sr[0];
  assign bus1.vji_tdo = bus1.vji_tdi;

  typedef struct {
    logic [W-1:0] rsp;
    logic [W-1:0] sr;
    int           cycle;
    int           uir_clks;
    logic [1:0]   ir;
  } exp_t;
  exp_t sb_q[$];

  logic       mdl_ir_valid = 1'b0;
  logic [1:0] mdl_ir       = 2'b00;

  // dut0 monitor: UIR observation and scoreboard compare.
  int         uir_clks = 0;
  logic [1:0] uir_ir   = 2'b00;
  int         rsp_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) uir_clks = 0;
    if (bus0.vji_uir) begin
      uir_clks++;
      uir_ir = bus0.vji_ir_in;
    end
    if (bus0.rsp_valid) begin
      rsp_seen++;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected_qsize", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("rsp_data", bus0.rsp_data, e.rsp);
        check("rsp_cycle", 64'(cyc), 64'(e.cycle));
        check("slave_sr_after_udr", slv_sr, e.sr);
        check("uir_clks", 64'(uir_clks), 64'(e.uir_clks));
        if (e.uir_clks > 0) check("uir_ir_in", uir_ir, e.ir);
      end
      uir_clks = 0;
    end
  end

  // dut1 monitor: strobe widths and overlap.
  int s1_uir = 0, s1_cdr = 0, s1_sdr = 0, s1_udr = 0, s1_ovl = 0;
  int rsp1_seen = 0, rsp1_cycle = 0;
  logic [W-1:0] rsp1_data = '0;
  always @(negedge clk) begin
    if (bus1.vji_uir) s1_uir++;
    if (bus1.vji_cdr) s1_cdr++;
    if (bus1.vji_sdr) s1_sdr++;
    if (bus1.vji_udr) s1_udr++;
    if ((int'(bus1.vji_uir) + int'(bus1.vji_cdr) + int'(bus1.vji_sdr) + int'(bus1.vji_udr)) > 1)
      s1_ovl++;
    if (bus1.rsp_valid) begin
      rsp1_seen++;
      rsp1_cycle = cyc;
      rsp1_data  = bus1.rsp_data;
    end
  end

  function automatic int exp_lat(input logic [1:0] ir);
    return (CACHE && mdl_ir_valid && (ir == mdl_ir)) ? LAT - 2 * TH : LAT;
  endfunction

  // Push an expectation for a command accepted at cycle acc, then advance the IR cache model.
  task automatic expect_cmd(input logic [1:0] ir, input logic [W-1:0] data,
                            input logic [W-1:0] rsp, input int acc, output int lat);
    exp_t e;
    lat        = exp_lat(ir);
    e.rsp      = rsp;
    e.sr       = data;
    e.cycle    = acc + lat;
    e.uir_clks = (lat == LAT) ? 2 * TH : 0;
    e.ir       = ir;
    sb_q.push_back(e);
    mdl_ir       = ir;
    mdl_ir_valid = 1'b1;
  endtask

  task automatic wait_ready0();
    int n = 0;
    @(negedge clk);
    while (!bus0.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.cmd_ready) check("cmd_ready_timeout", bus0.cmd_ready, 1'b1);
  endtask

  task automatic send(input logic [1:0] ir, input logic [W-1:0] data,
                      input logic [W-1:0] cap, input logic [W-1:0] rsp);
    int lat;
    wait_ready0();
    slv_cap        = cap;
    bus0.cmd_ir    = ir;
    bus0.cmd_data  = data;
    bus0.cmd_valid = 1'b1;
    expect_cmd(ir, data, rsp, cyc + 1, lat);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    bus0.cmd_data  = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus0.cmd_ready, 1'b1);
    check({tag, "_rsp_valid"}, bus0.rsp_valid, 1'b0);
    check({tag, "_rsp_data"},  bus0.rsp_data, '0);
    check({tag, "_tck"},       bus0.vji_tck, 1'b0);
    check({tag, "_tdi"},       bus0.vji_tdi, 1'b0);
    check({tag, "_ir_in"},     bus0.vji_ir_in, 2'b00);
    check({tag, "_rti"},       bus0.vji_rti, 1'b1);
    check({tag, "_strobes"},   {bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr}, 4'b0000);
  endtask

  typedef struct {
    logic [1:0]   ir;
    logic [W-1:0] data;
    logic [W-1:0] cap;
    logic [W-1:0] exp_rsp;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int viol, lat_a, lat_b, acc_a, n, rsp_before;
    vecs[0] = '{ir: 2'b01, data: 38'h00_0000_0AA5, cap: 38'h2A_BCDE_F012, exp_rsp: 38'h2A_BCDE_F012};
    vecs[1] = '{ir: 2'b10, data: 38'h3F_FFFF_FFFF, cap: 38'h00_0000_0000, exp_rsp: 38'h00_0000_0000};
    vecs[2] = '{ir: 2'b10, data: 38'h00_0000_0000, cap: 38'h3F_FFFF_FFFF, exp_rsp: 38'h3F_FFFF_FFFF};
    vecs[3] = '{ir: 2'b11, data: 38'h15_5555_5555, cap: 38'h2A_AAAA_AAAA, exp_rsp: 38'h2A_AAAA_AAAA};

    bus0.cmd_valid = 1'b0; bus0.cmd_ir = 2'b00; bus0.cmd_data = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = 2'b00; bus1.cmd_data = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;

    // Idle for 100 cycles with no command.
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus0.vji_rti !== 1'b1 || bus0.cmd_ready !== 1'b1 || bus0.vji_tck !== 1'b0 ||
          bus0.rsp_valid !== 1'b0 ||
          {bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr} !== 4'b0000)
        viol++;
    end
    check("idle_violations", 64'(viol), 64'd0);

    foreach (vecs[i]) begin
      send(vecs[i].ir, vecs[i].data, vecs[i].cap, vecs[i].exp_rsp);
      wait_drain();
    end

    // Strobe widths and latency on the TCK_HALF=1 instance (loopback: rsp equals data).
    @(negedge clk);
    bus1.cmd_ir    = 2'b10;
    bus1.cmd_data  = 38'h12_3456_789A;
    bus1.cmd_valid = 1'b1;
    acc_a = cyc + 1;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    for (int i = 0; i < 500 && rsp1_seen == 0; i++) @(negedge clk);
    check("tck1_rsp_seen", 64'(rsp1_seen), 64'd1);
    check("tck1_latency", 64'(rsp1_cycle - acc_a), 64'(LAT1));
    check("tck1_rsp_data", rsp1_data, 38'h12_3456_789A);
    check("tck1_uir_clks", 64'(s1_uir), 64'd2);
    check("tck1_cdr_clks", 64'(s1_cdr), 64'd2);
    check("tck1_sdr_clks", 64'(s1_sdr), 64'(2 * W));
    check("tck1_udr_clks", 64'(s1_udr), 64'd2);
    check("tck1_overlap",  64'(s1_ovl), 64'd0);

    // Back-to-back: cmd_valid held high, second command taken on the rsp_valid cycle.
    wait_ready0();
    slv_cap        = 38'h0F_0F0F_0F0F;
    bus0.cmd_ir    = 2'b11;
    bus0.cmd_data  = 38'h30_1234_5678;
    bus0.cmd_valid = 1'b1;
    acc_a = cyc + 1;
    expect_cmd(2'b11, 38'h30_1234_5678, 38'h0F_0F0F_0F0F, acc_a, lat_a);
    @(negedge clk);
    bus0.cmd_ir   = 2'b11;
    bus0.cmd_data = 38'h01_8765_4321;
    expect_cmd(2'b11, 38'h01_8765_4321, 38'h0F_0F0F_0F0F, acc_a + lat_a + 1, lat_b);
    n = 0;
    while (!bus0.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_valid_at_accept", bus0.rsp_valid, 1'b1);
    check("b2b_second_accept_cycle", 64'(cyc + 1), 64'(acc_a + lat_a + 1));
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    wait_drain();

    // Reset at the start of SDR bit 10, then a normal command.
    wait_ready0();
    slv_cap        = 38'h11_2233_4455;
    bus0.cmd_ir    = 2'b01;
    bus0.cmd_data  = 38'h2F_EDCB_A987;
    bus0.cmd_valid = 1'b1;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus0.vji_sdr) n++;
      if (n == 10 * 2 * TH + 1) break;
    end
    check("sdr_bit10_reached", 64'(n), 64'(10 * 2 * TH + 1));
    rsp_before   = rsp_seen;
    reset_n      = 1'b0;
    mdl_ir_valid = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_rsp_after_abort", 64'(rsp_seen - rsp_before), 64'd0);
    send(2'b01, 38'h2F_EDCB_A987, 38'h11_2233_4455, 38'h11_2233_4455);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
